adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined successor of the combinational `adder_<params>` block.
- Splits a WIDTH-bit add into STAGES carry-chunk stages so wide adds close timing.
- Optional carry-in.
- Valid/ready handshake on both sides with backpressure.
- Sits between operand producers and downstream consumers in datapath pipelines where a single-cycle wide add misses timing.

Parameters:
- WIDTH, 32, operand width in bits (>=1).
- STAGES, 2, pipeline stages / carry chunks (1..WIDTH).
- HAS_CIN, 0, 1 = cin participates in the add; 0 = cin ignored (treated as 0).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/cin valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in; used only when HAS_CIN=1.
- out_valid  output  1  sum valid.
- out_ready  input  1  downstream accepts sum.
- sum  output  WIDTH+1  a+b(+cin); MSB is carry-out.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Chunking:
  - CHUNK = ceil(WIDTH/STAGES).
  - Stage k (k=0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of a and b, clipped at WIDTH-1, plus the carry registered from stage k-1.
  - Stage 0 carry-in = (HAS_CIN ? cin : 0).
  - If the last chunk is empty (STAGES*CHUNK-CHUNK >= WIDTH), that stage just forwards.
- Datapath:
  - Each stage registers its partial sum bits and its carry-out.
  - Unprocessed upper operand chunks and completed lower sum chunks are delayed with the transaction.
  - sum[WIDTH] = carry-out of the final chunk.
- Arithmetic: unsigned, exact, no truncation. Full-scale a=b=2^WIDTH-1 with cin=1 gives sum = 2^(WIDTH+1)-1.
- Pipeline control: global enable en = !out_valid || out_ready.
  - in_ready = en (combinational from out_valid/out_ready; no path from in_valid).
  - When en=1, all stages shift one position. Stage-0 valid loads in_valid and operands are captured.
  - When en=0, all stage registers hold, and sum/out_valid are stable until accepted.
  - Bubbles are not collapsed, so an in-flight bubble advances only when en=1.
- Latency: exactly STAGES enabled cycles from the accepting edge (in_valid && in_ready) to out_valid=1.
  - STAGES=1 gives one-cycle registered add.
  - Throughput: 1 add/cycle when out_ready is held high.
- Ordering: strict FIFO, no reordering or dropping.
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear, so out_valid=0, and in_ready=1 the following cycle.
  - sum=0; all data registers clear.
  - In-flight transactions are discarded, and operands presented during the reset cycle are not captured.
- Simultaneous events:
  - out_ready and a new input in the same cycle with a full pipeline: output retires and input enters on the same edge.
  - out_ready=1 while out_valid=0 has no effect beyond allowing shift.
- Handshake rules for inputs: a/b/cin may change freely when in_valid=0.
- Handshake rules for outputs: sum is guaranteed only when out_valid=1.

Optional Feature:
- Macro ADDER_PIPE_SIGNED_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), aligned with sum/out_valid.
  - ovf = 1 when a+b(+cin) interpreted as WIDTH-bit two's complement overflows, i.e. sign(a)==sign(b) && sign(sum[WIDTH-1]) != sign(a).
  - ovf resets to 0 and holds under stall like sum.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=35, STAGES=3, HAS_CIN=0: a=0x7_FFFF_FFFF, b=1, out_ready=1 -> out_valid rises exactly 3 cycles after acceptance, sum=0x8_0000_0000 (carry ripples across all 3 chunks).
- WIDTH=35, STAGES=3, HAS_CIN=1: a=b=0x7_FFFF_FFFF, cin=1 -> sum=0xF_FFFF_FFFF. Same vector with HAS_CIN=0 -> sum=0xF_FFFF_FFFE.
- Back-to-back stream of 8 random pairs, out_ready=1 -> 8 consecutive out_valid cycles, sums in order matching a+b, in_ready constantly 1.
- Backpressure, pipeline full: out_ready=0 for 5 cycles -> in_ready=0, sum/out_valid held stable. Release -> results drain in order, none lost or duplicated.
- Reset mid-operation: accept 2 adds, assert rst 1 cycle before the first completes -> out_valid=0, sum=0 next cycle, in_ready=1, neither result ever appears.
- With ADDER_PIPE_SIGNED_OVF_EN, WIDTH=8, STAGES=2: a=0x7F, b=0x01 -> sum=0x080, ovf=1. a=0xFF, b=0x01 -> sum=0x100, ovf=0.

Source files
------------

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined chunked adder with valid/ready handshake; optional ovf via ADDER_PIPE_SIGNED_OVF_EN
module adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int HAS_CIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef ADDER_PIPE_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST  = STAGES - 1;

    // Stage registers: k holds the transaction after chunk k has been added.
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;

    // Inputs seen by each stage (operands for stage 0, previous stage otherwise).
    logic [STAGES-1:0]            src_v;
    logic [STAGES-1:0][WIDTH-1:0] src_a;
    logic [STAGES-1:0][WIDTH-1:0] src_b;
    logic [STAGES-1:0][WIDTH-1:0] src_s;
    logic [STAGES-1:0]            src_c;

    // Next-state of each stage after its chunk add.
    logic [STAGES-1:0][WIDTH-1:0] nxt_s;
    logic [STAGES-1:0]            nxt_c;

    logic en;
    logic cin_eff;
    logic unused_sink;

    assign cin_eff = (HAS_CIN != 0) ? cin : 1'b0;

    // The whole pipe advances together; a full pipe stalls only when the
    // output is held, so in_ready never depends on in_valid.
    assign en        = !v_q[LAST] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[LAST];
    assign sum       = {c_q[LAST], s_q[LAST]};

`ifdef ADDER_PIPE_SIGNED_OVF_EN
    // Operands travel with the transaction, so their signs are available at
    // the output stage without extra registers.
    assign ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                 (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`endif

    // Processed operand bits are carried but not consumed downstream.
    assign unused_sink = ^{cin, a_q, b_q};

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * CHUNK;

            if (k == 0) begin : g_src_in
                assign src_v[k] = in_valid;
                assign src_a[k] = a;
                assign src_b[k] = b;
                assign src_s[k] = '0;
                assign src_c[k] = cin_eff;
            end else begin : g_src_prev
                assign src_v[k] = v_q[k-1];
                assign src_a[k] = a_q[k-1];
                assign src_b[k] = b_q[k-1];
                assign src_s[k] = s_q[k-1];
                assign src_c[k] = c_q[k-1];
            end

            if (LO < WIDTH) begin : g_add
                localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
                localparam int CW = HI - LO + 1;
                localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - CW)) << LO;

                logic [CW:0] part;

                assign part = {1'b0, src_a[k][HI:LO]} + {1'b0, src_b[k][HI:LO]} +
                              {{CW{1'b0}}, src_c[k]};
                assign nxt_s[k] = (src_s[k] & ~MASK) | (WIDTH'(part[CW-1:0]) << LO);
                assign nxt_c[k] = part[CW];
            end else begin : g_forward
                // Empty trailing chunk when WIDTH does not fill every stage.
                assign nxt_s[k] = src_s[k];
                assign nxt_c[k] = src_c[k];
            end
        end
    endgenerate

    // Shift every stage on enable; reset clears valids and all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
        end else if (en) begin
            v_q <= src_v;
            a_q <= src_a;
            b_q <= src_b;
            s_q <= nxt_s;
            c_q <= nxt_c;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe
module tb_adder_pipe;

    localparam int W = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, cin, out_ready;
    logic [W-1:0] a, b;

    logic         ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [W:0]   s_a, s_b;
    logic [4:0]   s_c;
`ifdef ADDER_PIPE_SIGNED_OVF_EN
    logic         ir_d, ov_d, ovf_d;
    logic [8:0]   s_d;
`endif

    adder_pipe #(.WIDTH(W), .STAGES(3), .HAS_CIN(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .a(a), .b(b), .cin(cin),
        .out_valid(ov_a), .out_ready(out_ready), .sum(s_a));

    adder_pipe #(.WIDTH(W), .STAGES(3), .HAS_CIN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .a(a), .b(b), .cin(cin),
        .out_valid(ov_b), .out_ready(out_ready), .sum(s_b));

    adder_pipe #(.WIDTH(4), .STAGES(3), .HAS_CIN(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .out_valid(ov_c), .out_ready(out_ready), .sum(s_c));

`ifdef ADDER_PIPE_SIGNED_OVF_EN
    adder_pipe #(.WIDTH(8), .STAGES(2), .HAS_CIN(0)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .out_valid(ov_d), .out_ready(out_ready), .sum(s_d), .ovf(ovf_d));
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] q_a[$], q_b[$], q_c[$], q_d[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input int wd, input bit hc, input logic [63:0] x,
                                          input logic [63:0] y, input logic ci);
        logic [63:0] m;
        m = (64'd1 << wd) - 64'd1;
        return (x & m) + (y & m) + ((hc && ci) ? 64'd1 : 64'd0);
    endfunction

    function automatic logic [63:0] model_d(input logic [7:0] x, input logic [7:0] y);
        logic [63:0] s;
        logic        o;
        s = model(8, 1'b0, 64'(x), 64'(y), 1'b0);
        o = (x[7] == y[7]) && (s[7] != x[7]);
        return {54'd0, o, s[8:0]};
    endfunction

    // Scoreboards: push on accepted input, pop and compare on accepted output.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
        end else begin
            if (ov_a && out_ready) begin
                if (q_a.size() == 0) chk("spurious_a", 64'(ov_a), 64'd0);
                else chk("sum_a", 64'(s_a), q_a.pop_front());
            end
            if (ov_b && out_ready) begin
                if (q_b.size() == 0) chk("spurious_b", 64'(ov_b), 64'd0);
                else chk("sum_b", 64'(s_b), q_b.pop_front());
            end
            if (ov_c && out_ready) begin
                if (q_c.size() == 0) chk("spurious_c", 64'(ov_c), 64'd0);
                else chk("sum_c", 64'(s_c), q_c.pop_front());
            end
            if (in_valid && ir_a) q_a.push_back(model(W, 1'b1, 64'(a), 64'(b), cin));
            if (in_valid && ir_b) q_b.push_back(model(W, 1'b0, 64'(a), 64'(b), cin));
            if (in_valid && ir_c) q_c.push_back(model(4, 1'b1, 64'(a), 64'(b), cin));
`ifdef ADDER_PIPE_SIGNED_OVF_EN
            if (ov_d && out_ready) begin
                if (q_d.size() == 0) chk("spurious_d", 64'(ov_d), 64'd0);
                else chk("sum_ovf_d", {54'd0, ovf_d, s_d}, q_d.pop_front());
            end
            if (in_valid && ir_d) q_d.push_back(model_d(a[7:0], b[7:0]));
`endif
        end
    end

    task automatic wait_out(input string tag, input int which);
        int  n;
        logic sel;
        n = 0;
        sel = 1'b0;
        while (n < 20) begin
            case (which)
                0: sel = ov_a;
`ifdef ADDER_PIPE_SIGNED_OVF_EN
                3: sel = ov_d;
`endif
                default: sel = ov_a;
            endcase
            if (sel) break;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk(tag, 64'(sel), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    initial begin
        int n, first, last, cnt;
        bit acc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov_a), 64'd0);
        chk("rst_sum", 64'(s_a), 64'd0);
        chk("rst_in_ready", 64'(ir_a), 64'd1);
        rst = 1'b0;

        // Carry ripple across all three chunks, latency check.
        a = 35'h7_FFFF_FFFF; b = 35'd1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!ov_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'd3);
        chk("ripple_sum", 64'(s_a), 64'h8_0000_0000);

        // Full-scale with and without carry-in.
        @(posedge clk); #1;
        a = 35'h7_FFFF_FFFF; b = 35'h7_FFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("fullscale_timeout", 0);
        chk("fullscale_cin", 64'(s_a), 64'hF_FFFF_FFFF);
        chk("fullscale_nocin", 64'(s_b), 64'hF_FFFF_FFFE);
        chk("fullscale_ov_b", 64'(ov_b), 64'd1);
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef ADDER_PIPE_SIGNED_OVF_EN
        a = 35'h7F; b = 35'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("ovf1_timeout", 3);
        chk("ovf_pos", {54'd0, ovf_d, s_d}, 64'h280);
        @(posedge clk); #1;
        a = 35'hFF; b = 35'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("ovf2_timeout", 3);
        chk("ovf_none", {54'd0, ovf_d, s_d}, 64'h100);
        repeat (2) @(posedge clk);
        #1;
`endif

        // Back-to-back stream of 8 random pairs.
        cnt = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 8) begin
                a = rnd(); b = rnd(); cin = 1'($urandom()); in_valid = 1'b1;
                chk("stream_in_ready", 64'(ir_a), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (ov_a) begin
                cnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("stream_count", 64'(cnt), 64'd8);
        chk("stream_consecutive", 64'(last - first + 1), 64'd8);

        // Backpressure: fill the pipe with out_ready low, hold 5 cycles.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = rnd(); b = rnd(); cin = 1'($urandom()); in_valid = 1'b1;
            n = 0;
            do begin
                acc = ir_a;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 10);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 64'(ir_a), 64'd0);
            chk("bp_out_valid", 64'(ov_a), 64'd1);
            chk("bp_hold_sum", 64'(s_a), (q_a.size() > 0) ? q_a[0] : 64'hDEAD);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drain_a", 64'(q_a.size()), 64'd0);

        // Reset one cycle before the first of two adds completes.
        a = rnd(); b = rnd(); in_valid = 1'b1;
        @(posedge clk); #1;
        a = rnd(); b = rnd();
        @(posedge clk); #1;
        a = rnd(); b = rnd(); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 64'(ov_a), 64'd0);
        chk("mid_rst_sum", 64'(s_a), 64'd0);
        chk("mid_rst_in_ready", 64'(ir_a), 64'd1);
        rst = 1'b0; in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        chk("final_q_a", 64'(q_a.size()), 64'd0);
        chk("final_q_b", 64'(q_b.size()), 64'd0);
        chk("final_q_c", 64'(q_c.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
